// File: rtl/aes_seq_ctrl.sv
// ---------------------------------------------------------------------------
// aes_seq_ctrl
//
// Sequencer that drives an aes_top core on behalf of an upstream requester.
// It accepts one command at a time, performs key expansion, encrypt or
// decrypt on the core, and returns the result block with an error flag.
// While an operation is outstanding, no other command is accepted.
//
// Upstream command channel (valid/ready):
//   cmd_valid, cmd_ready, cmd_op (00 key-exp, 01 enc, 10 dec, 11 reserved),
//   cmd_aes256 (key size for key expansion), cmd_key, cmd_blk
// Upstream result channel (valid/ready):
//   res_valid, res_ready, res_blk, res_err
// Downstream (aes_top):
//   aes_en, aes128_mode, aes256_mode, cipher_mode, decipher_mode,
//   key_exp_mode, aes_key, aes_in_blk  -> core
//   aes_out_blk, aes_en_o (done strobe) <- core
// Clock/reset: clk, reset (synchronous, active low)
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed between the aes_en pulse and aes_en_o
//   TMO_W           watchdog width, must be able to hold TIMEOUT_CYCLES
//   KEY_W / BLK_W   key and block widths of the attached aes_top
//
// Optional build macro AES_SEQ_CTRL_STATS_EN adds:
//   blk_count (32b, wraps)      successful cipher/decipher result handshakes
//   err_count (16b, saturates)  error result handshakes
// ---------------------------------------------------------------------------
module aes_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7,
  parameter int KEY_W          = 256,
  parameter int BLK_W          = 128
) (
  input  logic             clk,
  input  logic             reset,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_aes256,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic [BLK_W-1:0] cmd_blk,
  // result channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BLK_W-1:0] res_blk,
  output logic             res_err,
  // aes_top interface
  output logic             aes_en,
  output logic             aes128_mode,
  output logic             aes256_mode,
  output logic             cipher_mode,
  output logic             decipher_mode,
  output logic             key_exp_mode,
  output logic [KEY_W-1:0] aes_key,
  output logic [BLK_W-1:0] aes_in_blk,
  input  logic [BLK_W-1:0] aes_out_blk,
  input  logic             aes_en_o
`ifdef AES_SEQ_CTRL_STATS_EN
  ,
  output logic [31:0]      blk_count,
  output logic [15:0]      err_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_KEYEXP = 2'b00,
    OP_ENC    = 2'b01,
    OP_DEC    = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  state_e           state_q;
  op_e              op_q;
  logic             key_loaded_q;
  logic             key256_q;
  logic [TMO_W-1:0] wd_q;

  logic             cmd_ready_q;
  logic             res_valid_q;
  logic [BLK_W-1:0] res_blk_q;
  logic             res_err_q;
  logic             aes_en_q;
  logic             aes128_q;
  logic             aes256_q;
  logic             cipher_q;
  logic             decipher_q;
  logic             key_exp_q;
  logic [KEY_W-1:0] aes_key_q;
  logic [BLK_W-1:0] aes_in_blk_q;

`ifdef AES_SEQ_CTRL_STATS_EN
  logic [31:0]      blk_count_q;
  logic [15:0]      err_count_q;
`endif

  // Key size actually presented to the core: a key-expansion command carries
  // its own size, cipher/decipher reuse the size of the last expanded key.
  logic cmd_key256;
  assign cmd_key256 = (op_e'(cmd_op) == OP_KEYEXP) ? cmd_aes256 : key256_q;

  // Commands that can be answered without touching the core.
  logic cmd_reject;
  assign cmd_reject = (op_e'(cmd_op) == OP_RSVD) ||
                      ((op_e'(cmd_op) != OP_KEYEXP) && !key_loaded_q);

  logic wd_expired;
  assign wd_expired = (wd_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // All outputs are registered; each state arm sets the values seen in the
  // state it transitions into.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; every register, wide
    // datapath ones included, is cleared so no stale key or block leaks out.
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_KEYEXP;
      key_loaded_q <= 1'b0;
      key256_q     <= 1'b0;
      wd_q         <= '0;
      cmd_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_blk_q    <= '0;
      res_err_q    <= 1'b0;
      aes_en_q     <= 1'b0;
      aes128_q     <= 1'b0;
      aes256_q     <= 1'b0;
      cipher_q     <= 1'b0;
      decipher_q   <= 1'b0;
      key_exp_q    <= 1'b0;
      aes_key_q    <= '0;
      aes_in_blk_q <= '0;
`ifdef AES_SEQ_CTRL_STATS_EN
      blk_count_q  <= '0;
      err_count_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register update
      // in this block sees the pre-edge value of every other register.
      unique case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= op_e'(cmd_op);
            if (op_e'(cmd_op) == OP_KEYEXP) begin
              key256_q <= cmd_aes256;
            end
            if (cmd_reject) begin
              state_q     <= S_RESP;
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
              res_blk_q   <= '0;
            end else begin
              state_q      <= S_ISSUE;
              aes_en_q     <= 1'b1;
              aes128_q     <= !cmd_key256;
              aes256_q     <= cmd_key256;
              cipher_q     <= (op_e'(cmd_op) == OP_ENC);
              decipher_q   <= (op_e'(cmd_op) == OP_DEC);
              key_exp_q    <= (op_e'(cmd_op) == OP_KEYEXP);
              aes_key_q    <= (op_e'(cmd_op) == OP_KEYEXP) ? cmd_key : '0;
              aes_in_blk_q <= cmd_blk;
            end
          end
        end

        S_ISSUE: begin
          aes_en_q <= 1'b0;
          wd_q     <= '0;
          state_q  <= S_WAIT;
        end

        S_WAIT: begin
          wd_q <= wd_q + TMO_W'(1);
          if (aes_en_o) begin
            res_blk_q <= aes_out_blk;
            if (op_q == OP_KEYEXP) begin
              // Key expansion completes silently; the core now holds the key.
              key_loaded_q <= 1'b1;
              state_q      <= S_IDLE;
              cmd_ready_q  <= 1'b1;
              aes128_q     <= 1'b0;
              aes256_q     <= 1'b0;
              cipher_q     <= 1'b0;
              decipher_q   <= 1'b0;
              key_exp_q    <= 1'b0;
              aes_key_q    <= '0;
              aes_in_blk_q <= '0;
            end else begin
              state_q     <= S_RESP;
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b0;
            end
          end else if (wd_expired) begin
            state_q     <= S_RESP;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            res_blk_q   <= '0;
            // A failed expansion leaves the core's key schedule undefined.
            if (op_q == OP_KEYEXP) begin
              key_loaded_q <= 1'b0;
            end
          end
        end

        S_RESP: begin
          if (res_ready) begin
            state_q      <= S_IDLE;
            res_valid_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            aes128_q     <= 1'b0;
            aes256_q     <= 1'b0;
            cipher_q     <= 1'b0;
            decipher_q   <= 1'b0;
            key_exp_q    <= 1'b0;
            aes_key_q    <= '0;
            aes_in_blk_q <= '0;
`ifdef AES_SEQ_CTRL_STATS_EN
            if (res_err_q) begin
              if (err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
              end
            end else begin
              blk_count_q <= blk_count_q + 32'd1;
            end
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign res_valid     = res_valid_q;
  assign res_blk       = res_blk_q;
  assign res_err       = res_err_q;
  assign aes_en        = aes_en_q;
  assign aes128_mode   = aes128_q;
  assign aes256_mode   = aes256_q;
  assign cipher_mode   = cipher_q;
  assign decipher_mode = decipher_q;
  assign key_exp_mode  = key_exp_q;
  assign aes_key       = aes_key_q;
  assign aes_in_blk    = aes_in_blk_q;

`ifdef AES_SEQ_CTRL_STATS_EN
  assign blk_count = blk_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_seq_ctrl
//
// Drives aes_seq_ctrl against a behavioural stand-in for aes_top. The stand-in
// answers with a programmable latency (or never), knows the FIPS-197 vectors
// for the two reference keys, and otherwise applies a self-inverse XOR
// transform so decrypt(encrypt(x)) == x. A command-level model tracks the
// loaded key and predicts every result, error flag and latency.
// ---------------------------------------------------------------------------
module tb_aes_seq_ctrl;

  localparam int TMO = 8;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic         cmd_aes256;
  logic [255:0] cmd_key;
  logic [127:0] cmd_blk;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_blk;
  logic         res_err;
  logic         aes_en;
  logic         aes128_mode;
  logic         aes256_mode;
  logic         cipher_mode;
  logic         decipher_mode;
  logic         key_exp_mode;
  logic [255:0] aes_key;
  logic [127:0] aes_in_blk;
  logic [127:0] aes_out_blk;
  logic         aes_en_o;
`ifdef AES_SEQ_CTRL_STATS_EN
  logic [31:0]  blk_count;
  logic [15:0]  err_count;
`endif

  aes_seq_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .TMO_W         (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_aes256   (cmd_aes256),
    .cmd_key      (cmd_key),
    .cmd_blk      (cmd_blk),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_blk      (res_blk),
    .res_err      (res_err),
    .aes_en       (aes_en),
    .aes128_mode  (aes128_mode),
    .aes256_mode  (aes256_mode),
    .cipher_mode  (cipher_mode),
    .decipher_mode(decipher_mode),
    .key_exp_mode (key_exp_mode),
    .aes_key      (aes_key),
    .aes_in_blk   (aes_in_blk),
    .aes_out_blk  (aes_out_blk),
    .aes_en_o     (aes_en_o)
`ifdef AES_SEQ_CTRL_STATS_EN
    ,
    .blk_count    (blk_count),
    .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural AES stand-in: real vectors for the reference keys, XOR
  // transform (its own inverse) for anything else.
  function automatic logic [127:0] aes_fn(input logic [255:0] k, input logic k256,
                                          input logic [127:0] b, input logic dec);
    if (!k256 && k == K128 && !dec && b == PT)    return CT128;
    if (!k256 && k == K128 &&  dec && b == CT128) return PT;
    if ( k256 && k == K256 && !dec && b == PT)    return CT256;
    if ( k256 && k == K256 &&  dec && b == CT256) return PT;
    return b ^ k[255:128] ^ k[127:0] ^ {127'h0, k256};
  endfunction

  // ---------------- aes_top stand-in ----------------
  int           stub_lat = 1;   // 0 = never answer
  logic [255:0] stub_key  = '0;
  logic         stub_k256 = 1'b0;
  int           en_pulses = 0;
  int           en_wide   = 0;
  int           issue_cyc = 0;
  logic         iss_a128, iss_a256, iss_cm, iss_dm, iss_km;
  logic [255:0] iss_key;
  logic [127:0] iss_blk;

  initial begin
    logic pend;
    logic prev_en;
    int   cnt;
    pend = 1'b0; prev_en = 1'b0; cnt = 0;
    aes_en_o = 1'b0; aes_out_blk = '0;
    forever begin
      @(negedge clk);
      aes_en_o = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else if (aes_en) begin
        if (prev_en) en_wide++;
        en_pulses++;
        issue_cyc = cyc;
        iss_a128 = aes128_mode; iss_a256 = aes256_mode;
        iss_cm = cipher_mode; iss_dm = decipher_mode; iss_km = key_exp_mode;
        iss_key = aes_key; iss_blk = aes_in_blk;
        pend = (stub_lat > 0);
        cnt = 0;
      end else if (pend) begin
        cnt++;
        if (cnt == stub_lat) begin
          pend = 1'b0;
          aes_en_o = 1'b1;
          if (iss_km) begin
            stub_key  = iss_key;
            stub_k256 = iss_a256;
            aes_out_blk = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            aes_out_blk = aes_fn(stub_key, stub_k256, iss_blk, iss_dm);
          end
        end
      end
      prev_en = aes_en;
    end
  end

  // ---------------- command-level reference model ----------------
  logic         m_loaded = 1'b0;
  logic         m_k256   = 1'b0;
  logic [255:0] m_key    = '0;
  int           m_blk_cnt = 0;
  int           m_err_cnt = 0;

  task automatic send_cmd(input logic [1:0] op, input logic k256,
                          input logic [255:0] key, input logic [127:0] blk);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_aes256 = k256; cmd_key = key; cmd_blk = blk;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic k256, input logic [255:0] key,
                         input logic [127:0] blk, input int lat, input int hold);
    logic         issues, tmo, has_res, exp_err, eff256;
    logic [127:0] exp_blk;
    int           p0, t;
    issues  = (op == 2'd0) || (op != 2'd3 && m_loaded);
    tmo     = issues && (lat == 0 || lat > TMO);
    has_res = !(op == 2'd0 && issues && !tmo);
    exp_err = !issues || tmo;
    exp_blk = exp_err ? 128'h0 : aes_fn(m_key, m_k256, blk, op == 2'd2);
    eff256  = (op == 2'd0) ? k256 : m_k256;
    p0 = en_pulses;
    stub_lat = lat;
    send_cmd(op, k256, key, blk);

    if (has_res) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!res_valid && t < 40);
      check("res_valid", res_valid, 1);
      if (issues) check("res_latency", cyc - issue_cyc, tmo ? TMO + 1 : lat + 1);
      check("res_err", res_err, exp_err);
      check("res_blk", res_blk, exp_blk);
      check("busy_rdy", cmd_ready, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", res_valid, 1);
        check("hold_blk", res_blk, exp_blk);
        check("hold_rdy", cmd_ready, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("res_drop", res_valid, 0);
      check("rdy_back", cmd_ready, 1);
    end else begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
        if (res_valid) check("kexp_no_res", res_valid, 0);
      end while (!cmd_ready && t < 40);
      check("kexp_done_lat", cyc - issue_cyc, lat + 1);
    end

    check("en_count", en_pulses - p0, issues ? 1 : 0);
    if (issues) begin
      check("mode_256", iss_a256, eff256);
      check("mode_128", iss_a128, !eff256);
      check("mode_op", {iss_cm, iss_dm, iss_km},
            {op == 2'd1, op == 2'd2, op == 2'd0});
      check("iss_key", iss_key, (op == 2'd0) ? key : 256'h0);
      check("iss_blk", iss_blk, blk);
    end

    if (op == 2'd0) begin
      m_k256 = k256;
      if (tmo) m_loaded = 1'b0;
      else begin
        m_loaded = 1'b1;
        m_key    = key;
      end
    end
    if (has_res) begin
      if (exp_err) m_err_cnt++;
      else m_blk_cnt++;
    end
`ifdef AES_SEQ_CTRL_STATS_EN
    @(negedge clk);
    check("blk_count", blk_count, m_blk_cnt);
    check("err_count", err_count, (m_err_cnt > 65535) ? 65535 : m_err_cnt);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {cmd_ready, res_valid, res_err, aes_en, aes128_mode, aes256_mode,
                           cipher_mode, decipher_mode, key_exp_mode}, 0);
    check({tag, "_resblk"}, res_blk, 0);
    check({tag, "_key"}, aes_key, 0);
    check({tag, "_inblk"}, aes_in_blk, 0);
`ifdef AES_SEQ_CTRL_STATS_EN
    check({tag, "_stats"}, {blk_count, err_count}, 0);
`endif
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_aes256 = 1'b0;
    cmd_key = '0; cmd_blk = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Directed: error paths, reference vectors, latency boundaries.
    run_cmd(2'd1, 1'b0, '0, PT, 3, 0);        // encrypt, no key loaded
    run_cmd(2'd3, 1'b0, '0, PT, 3, 1);        // reserved op
    run_cmd(2'd0, 1'b0, K128, '0, 3, 0);      // key exp 128
    run_cmd(2'd1, 1'b0, '0, PT, 5, 5);        // encrypt, result held 5 cycles
    run_cmd(2'd2, 1'b0, '0, CT128, TMO, 0);   // decrypt at max latency
    run_cmd(2'd0, 1'b1, K256, '0, 1, 0);      // key exp 256
    run_cmd(2'd1, 1'b0, '0, PT, 2, 0);        // encrypt 256
    run_cmd(2'd1, 1'b0, '0, PT, 0, 2);        // core hangs -> timeout
    run_cmd(2'd2, 1'b0, '0, CT256, TMO + 1, 0); // late done is ignored
    run_cmd(2'd0, 1'b0, K128, '0, 0, 0);      // key exp timeout
    run_cmd(2'd1, 1'b0, '0, PT, 3, 0);        // key now unloaded
    run_cmd(2'd0, 1'b0, K128, '0, 4, 0);
    run_cmd(2'd1, 1'b0, '0, PT, 1, 0);

    // Reset while waiting on the core.
    stub_lat = 0;
    send_cmd(2'd1, 1'b0, '0, PT);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b1;
    m_loaded = 1'b0; m_k256 = 1'b0; m_blk_cnt = 0; m_err_cnt = 0;
    run_cmd(2'd1, 1'b0, '0, PT, 2, 0);        // key cleared by reset

    // Stats scenario: one no-key error then three good encrypts.
    run_cmd(2'd0, 1'b0, K128, '0, 2, 0);
    for (int i = 0; i < 3; i++) run_cmd(2'd1, 1'b0, '0, PT, i + 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int           r, rl, lat;
      logic [1:0]   op;
      logic [255:0] key;
      logic [127:0] blk;
      r  = $urandom_range(0, 9);
      op = (r < 2) ? 2'd0 : (r < 5) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd3 : 2'd1;
      rl = $urandom_range(0, 12);
      lat = (rl <= 9) ? rl : $urandom_range(1, 4);
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      blk = {$urandom, $urandom, $urandom, $urandom};
      run_cmd(op, 1'($urandom_range(0, 1)), key, blk, lat, $urandom_range(0, 3));
    end

    check("en_single_cycle", en_wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
